// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, frame width and the default bit period
// used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        UART_STATE_IDLE  = 2'd0,
        UART_STATE_START = 2'd1,
        UART_STATE_DATA  = 2'd2,
        UART_STATE_STOP  = 2'd3
    } uart_state_t;

    localparam int UART_DATA_BITS = 8;

    // 115200 baud from a 125 MHz system clock
    localparam int UART_DEFAULT_BAUD_LENGTH = 125000000 / 115200;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..BAUD_LENGTH_IN_CYCLES-1 and wraps, flagging the half-bit
// and last-cycle points. Shared between the UART receiver and transmitter.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int BAUD_LENGTH_IN_CYCLES = UART_DEFAULT_BAUD_LENGTH
) (
    input  logic sysclk,
    input  logic rst,
    input  logic clear,
    output logic half_tick,
    output logic full_tick
);

    localparam int CNT_W = $clog2(BAUD_LENGTH_IN_CYCLES) + 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_LENGTH_IN_CYCLES / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BAUD_LENGTH_IN_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge sysclk) begin
        if (rst || clear || full_tick) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign half_tick = (count == HALF_LAST);
    assign full_tick = (count == FULL_LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises the serial pin, samples each bit mid-period and hands
// bytes to the consumer through a one-entry valid/ready holding register.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_LENGTH_IN_CYCLES = UART_DEFAULT_BAUD_LENGTH,
    parameter int SYNC_STAGES           = 2
) (
    input  logic                      sysclk,
    input  logic                      rst,
    input  logic                      UART_RX,
    output logic [UART_DATA_BITS-1:0] data_out,
    output logic                      data_valid,
    input  logic                      data_ready,
    output logic                      busy,
    output logic                      framing_error,
    output logic                      overrun
);

    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    logic [SYNC_STAGES-1:0]    sync_ff;
    logic                      rx_s;
    logic                      rx_prev;
    uart_state_t               state;
    uart_state_t               state_next;
    logic [2:0]                bit_idx;
    logic [UART_DATA_BITS-1:0] shift_reg;
    logic                      timer_clear;
    logic                      half_tick;
    logic                      full_tick;
    logic                      stop_sample;

    // Synchroniser and edge-detect history reset to the idle (high) line level
    always_ff @(posedge sysclk) begin
        if (rst) begin
            sync_ff <= '1;
            rx_prev <= 1'b1;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], UART_RX};
            rx_prev <= rx_s;
        end
    end

    assign rx_s = sync_ff[SYNC_STAGES-1];

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state <= UART_STATE_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            UART_STATE_IDLE:  if (rx_prev && !rx_s) state_next = UART_STATE_START;
            UART_STATE_START: if (half_tick) state_next = rx_s ? UART_STATE_IDLE : UART_STATE_DATA;
            UART_STATE_DATA:  if (full_tick && bit_idx == LAST_BIT) state_next = UART_STATE_STOP;
            UART_STATE_STOP:  if (full_tick) state_next = UART_STATE_IDLE;
            default:          state_next = UART_STATE_IDLE;
        endcase
    end

    // Timer is held at zero while idle so it never wraps between frames
    assign timer_clear = (state_next != state) || (state == UART_STATE_IDLE);
    assign stop_sample = (state == UART_STATE_STOP) && full_tick;
    assign busy        = (state != UART_STATE_IDLE);

    uart_bit_timer #(
        .BAUD_LENGTH_IN_CYCLES(BAUD_LENGTH_IN_CYCLES)
    ) u_bit_timer (
        .sysclk   (sysclk),
        .rst      (rst),
        .clear    (timer_clear),
        .half_tick(half_tick),
        .full_tick(full_tick)
    );

    always_ff @(posedge sysclk) begin
        if (rst) begin
            bit_idx       <= '0;
            shift_reg     <= '0;
            data_out      <= '0;
            data_valid    <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            framing_error <= stop_sample && !rx_s;
            overrun       <= stop_sample && rx_s && data_valid && !data_ready;

            if (state == UART_STATE_START) begin
                bit_idx <= '0;
            end else if (state == UART_STATE_DATA && full_tick) begin
                shift_reg <= {rx_s, shift_reg[UART_DATA_BITS-1:1]};
                bit_idx   <= bit_idx + 3'd1;
            end

            // A fresh byte may replace one being accepted this same cycle
            if (stop_sample && rx_s && (!data_valid || data_ready)) begin
                data_out   <= shift_reg;
                data_valid <= 1'b1;
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 8 cycles per bit: drives ideal 8N1 frames and checks
// bytes, handshake, flags and timing against hand-computed values.
module tb_uart_rx;

    localparam int B = 8;

    logic       sysclk = 1'b0;
    logic       rst = 1'b1;
    logic       UART_RX = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready = 1'b0;
    logic       busy;
    logic       framing_error;
    logic       overrun;

    int vectors = 0;
    int miscompares = 0;

    int   cyc = 0;
    int   rise_cyc = 0;
    int   valid_cycles = 0;
    int   fe_count = 0;
    int   ov_count = 0;
    int   busy_cycles = 0;
    logic valid_q = 1'b0;
    logic [7:0] xfer_q[$];

    uart_rx #(
        .BAUD_LENGTH_IN_CYCLES(B),
        .SYNC_STAGES(2)
    ) dut (
        .sysclk       (sysclk),
        .rst          (rst),
        .UART_RX      (UART_RX),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .busy         (busy),
        .framing_error(framing_error),
        .overrun      (overrun)
    );

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) cyc++;

    // Observes outputs mid-cycle; inputs only change just after the rising edge
    always @(negedge sysclk) begin
        if (data_valid && !valid_q) rise_cyc = cyc;
        valid_q = data_valid;
        if (data_valid) valid_cycles++;
        if (data_valid && data_ready) xfer_q.push_back(data_out);
        if (framing_error) fe_count++;
        if (overrun) ov_count++;
        if (busy) busy_cycles++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    task automatic drive_bits(input logic [9:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            UART_RX = bits[i];
            tick(B);
        end
    endtask

    task automatic send_frame(input logic [7:0] value, input logic stop_bit);
        drive_bits({stop_bit, value, 1'b0}, 10);
    endtask

    task automatic flush_byte();
        data_ready = 1'b1;
        tick(1);
        data_ready = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        vectors++;
        if ({data_valid, busy, framing_error, overrun} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got %b expected 0000", {data_valid, busy, framing_error, overrun});
        end
        vectors++;
        if (data_out !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL reset_data: got %h expected 00", data_out);
        end
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_single_byte();
        int t0, fe0, ov0;
        fe0 = fe_count;
        ov0 = ov_count;
        t0 = cyc;
        send_frame(8'h41, 1'b1);
        tick(2);
        vectors++;
        if (data_valid !== 1'b1 || data_out !== 8'h41) begin
            miscompares++;
            $display("[TB] FAIL single_byte: got valid=%b data=%h expected valid=1 data=41", data_valid, data_out);
        end
        vectors++;
        if (rise_cyc - t0 < 78 || rise_cyc - t0 > 80) begin
            miscompares++;
            $display("[TB] FAIL latency: got %0d expected 79 (+/-1)", rise_cyc - t0);
        end
        vectors++;
        if (fe_count != fe0 || ov_count != ov0) begin
            miscompares++;
            $display("[TB] FAIL single_flags: got fe=%0d ov=%0d expected 0 0", fe_count - fe0, ov_count - ov0);
        end
        flush_byte();
        vectors++;
        if (data_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL single_drain: got valid=%b expected 0", data_valid);
        end
    endtask

    task automatic test_back_to_back();
        int q0, v0;
        logic [7:0] exp_bytes[3] = '{8'h00, 8'hFF, 8'h55};
        q0 = xfer_q.size();
        v0 = valid_cycles;
        data_ready = 1'b1;
        for (int i = 0; i < 3; i++) send_frame(exp_bytes[i], 1'b1);
        tick(2 * B);
        data_ready = 1'b0;
        vectors++;
        if (xfer_q.size() - q0 != 3) begin
            miscompares++;
            $display("[TB] FAIL b2b_count: got %0d expected 3", xfer_q.size() - q0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (xfer_q[q0 + i] !== exp_bytes[i]) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_byte%0d: got %h expected %h", i, xfer_q[q0 + i], exp_bytes[i]);
                end
            end
        end
        vectors++;
        if (valid_cycles - v0 != 3) begin
            miscompares++;
            $display("[TB] FAIL b2b_beats: got %0d valid cycles expected 3", valid_cycles - v0);
        end
    endtask

    task automatic test_framing_error();
        int fe0, v0;
        fe0 = fe_count;
        v0 = valid_cycles;
        send_frame(8'h41, 1'b0);
        tick(3 * B);
        vectors++;
        if (fe_count - fe0 != 1) begin
            miscompares++;
            $display("[TB] FAIL framing_pulse: got %0d cycles expected 1", fe_count - fe0);
        end
        vectors++;
        if (valid_cycles != v0 || data_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL framing_valid: got %0d valid cycles expected 0", valid_cycles - v0);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL framing_rearm: got busy=%b expected 0 with line held low", busy);
        end
        UART_RX = 1'b1;
        tick(2 * B);
    endtask

    task automatic test_overrun();
        int ov0, fe0;
        ov0 = ov_count;
        fe0 = fe_count;
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        tick(2);
        vectors++;
        if (ov_count - ov0 != 1 || fe_count != fe0) begin
            miscompares++;
            $display("[TB] FAIL overrun_pulse: got ov=%0d fe=%0d expected 1 0", ov_count - ov0, fe_count - fe0);
        end
        vectors++;
        if (data_valid !== 1'b1 || data_out !== 8'h12) begin
            miscompares++;
            $display("[TB] FAIL overrun_hold: got valid=%b data=%h expected valid=1 data=12", data_valid, data_out);
        end
        data_ready = 1'b1;
        tick(1);
        vectors++;
        if (data_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL overrun_drain: got valid=%b expected 0", data_valid);
        end
        data_ready = 1'b0;
        vectors++;
        if (xfer_q.size() == 0 || xfer_q[xfer_q.size() - 1] !== 8'h12) begin
            miscompares++;
            $display("[TB] FAIL overrun_xfer: got %h expected 12", (xfer_q.size() == 0) ? 8'hxx : xfer_q[xfer_q.size() - 1]);
        end
        tick(B);
    endtask

    task automatic test_glitch();
        int b0, v0, fe0, ov0;
        b0 = busy_cycles;
        v0 = valid_cycles;
        fe0 = fe_count;
        ov0 = ov_count;
        UART_RX = 1'b0;
        tick(3);
        UART_RX = 1'b1;
        tick(2 * B);
        vectors++;
        if (busy_cycles - b0 != B / 2) begin
            miscompares++;
            $display("[TB] FAIL glitch_busy: got %0d busy cycles expected %0d", busy_cycles - b0, B / 2);
        end
        vectors++;
        if (valid_cycles != v0 || fe_count != fe0 || ov_count != ov0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL glitch_quiet: got valid=%0d fe=%0d ov=%0d busy=%b expected 0 0 0 0",
                     valid_cycles - v0, fe_count - fe0, ov_count - ov0, busy);
        end
    endtask

    task automatic test_reset_mid_frame();
        send_frame(8'h77, 1'b1);
        tick(2);
        drive_bits({1'b1, 8'hA5, 1'b0}, 4);
        vectors++;
        if (busy !== 1'b1 || data_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL midframe_pre: got busy=%b valid=%b expected 1 1", busy, data_valid);
        end
        rst = 1'b1;
        tick(1);
        vectors++;
        if ({data_valid, busy, framing_error, overrun} !== 4'b0000 || data_out !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL midframe_reset: got flags=%b data=%h expected 0000 00",
                     {data_valid, busy, framing_error, overrun}, data_out);
        end
        rst = 1'b0;
        UART_RX = 1'b1;
        tick(3 * B);
        send_frame(8'h3C, 1'b1);
        tick(2);
        vectors++;
        if (data_valid !== 1'b1 || data_out !== 8'h3C) begin
            miscompares++;
            $display("[TB] FAIL after_reset: got valid=%b data=%h expected valid=1 data=3c", data_valid, data_out);
        end
        flush_byte();
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_framing_error();
        test_overrun();
        test_glitch();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
